// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the frame accumulator; SUM_ACC_SAT_EN selects clamping in sat_add.
// Latency: none (declarations only).  Backpressure: n/a.
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } sum_acc_state_t;

    localparam int unsigned SUM_W   = 64;
    localparam logic [63:0] SUM_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SUM_MIN = 64'h8000_0000_0000_0000;

    // Overflow when both operands share a sign that the result does not.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            output logic       ovf);
        logic [63:0] r;
        r   = a + b;
        ovf = (a[63] == b[63]) && (r[63] != a[63]);
`ifdef SUM_ACC_SAT_EN
        if (ovf) begin
            r = a[63] ? SUM_MIN : SUM_MAX;
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/sum_acc_add.sv
// Signed add with overflow detect; clamps on overflow when SUM_ACC_SAT_EN is defined, wraps otherwise.
// Latency: combinational.  Backpressure: n/a.
module sum_acc_add
    import sum_acc_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    generate
        if (DATA_W == SUM_W) begin : g_pkg
            always_comb begin
                sum = sat_add(a, b, ovf);
            end
        end else begin : g_generic
            localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
            localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
            logic [DATA_W-1:0] raw;
            always_comb begin
                raw = a + b;
                ovf = (a[DATA_W-1] == b[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1]);
                sum = raw;
`ifdef SUM_ACC_SAT_EN
                if (ovf) begin
                    sum = a[DATA_W-1] ? MIN_V : MAX_V;
                end
`endif
            end
        end
    endgenerate

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates FRAME_LEN signed samples (or fewer on flush) into one total with sticky overflow; SUM_ACC_SAT_EN clamps.
// Latency: out_valid one cycle after the closing accept/flush.  Backpressure: in_ready low while a total is held.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

    sum_acc_state_t    state;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    logic [DATA_W-1:0] add_sum;
    logic              add_ovf;
    logic [CNT_W-1:0]  cnt_inc;
    logic              accept;

    sum_acc_add #(.DATA_W(DATA_W)) u_add (
        .a   (acc),
        .b   (in_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign accept  = in_valid && in_ready;
    assign cnt_inc = cnt + 1'b1;

    // The running registers double as the output holding registers.
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= add_sum;
                        cnt <= cnt_inc;
                        ovf <= ovf | add_ovf;
                        if (cnt_inc == FRAME_CNT || flush) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end else if (flush && cnt != '0) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: directed frames plus random frames against a 65-bit model.
module tb_sum_accumulator;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 3;
    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic [63:0]      sum;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    int   checks = 0;
    int   fails  = 0;
    bit   rnd_rdy = 1'b0;
    exp_t exp_q[$];

    sum_accumulator #(.DATA_W(DATA_W), .FRAME_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a handshake completes at the next rising edge when both are high here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_sum",   out_sum, e.sum);
                check("out_count", 64'(out_count), 64'(e.cnt));
                check("out_ovf",   64'(out_ovf), 64'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [63:0] d, input logic fl);
        logic took;
        int   n;
        took = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        while (!took && n < 100) begin
            took = in_ready;
            tick();
            n++;
        end
        if (!took) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    task automatic model_add(input logic [63:0] a_in, input logic o_in, input logic [63:0] d,
                             output logic [63:0] a_out, output logic o_out);
        logic [64:0] w;
        w = {a_in[63], a_in} + {d[63], d};
        a_out = w[63:0];
        o_out = o_in;
        if (w[64] != w[63]) begin
            o_out = 1'b1;
`ifdef SUM_ACC_SAT_EN
            a_out = w[64] ? MINV : MAXV;
`endif
        end
    endtask

    initial begin
        logic [63:0] s [4];
        logic [63:0] macc;
        logic        movf;
        int          len;
        bit          lone_flush;
        exp_t        e;

        // Reset and reset mid-frame
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        send(64'd5, 1'b0);
        send(64'd6, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_sum",   out_sum, 64'd0);
        check("midrst_out_count", 64'(out_count), 64'd0);
        check("midrst_out_ovf",   64'(out_ovf), 64'd0);
        check("midrst_in_ready",  64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back('{sum: 64'd10, cnt: 3'd4, ovf: 1'b0});
        send(64'd1, 1'b0); send(64'd2, 1'b0); send(64'd3, 1'b0); send(64'd4, 1'b0);
        drain();

        // Full frame
        exp_q.push_back('{sum: 64'd13, cnt: 3'd4, ovf: 1'b0});
        send(64'd5, 1'b0); send(-64'sd3, 1'b0); send(64'd10, 1'b0); send(64'd1, 1'b0);
        drain();

        // Backpressure: held output stable, input stalled, flush in HOLD ignored
        out_ready = 1'b0;
        exp_q.push_back('{sum: 64'd13, cnt: 3'd4, ovf: 1'b0});
        send(64'd5, 1'b0); send(-64'sd3, 1'b0); send(64'd10, 1'b0); send(64'd1, 1'b0);
        in_valid = 1'b1;
        in_data  = 64'd99;
        flush    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_sum",   out_sum, 64'd13);
            check("bp_out_count", 64'(out_count), 64'd4);
            check("bp_in_ready",  64'(in_ready), 64'd0);
            tick();
        end
        exp_q.push_back('{sum: 64'd99, cnt: 3'd1, ovf: 1'b0});
        out_ready = 1'b1;
        send(64'd99, 1'b1);
        drain();

        // Flush with a same-cycle sample, then a lone flush in IDLE
        exp_q.push_back('{sum: 64'd16, cnt: 3'd3, ovf: 1'b0});
        send(64'd7, 1'b0); send(64'd8, 1'b0); send(64'd1, 1'b1);
        drain();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("lone_flush_out_valid", 64'(out_valid), 64'd0);
        check("lone_flush_in_ready",  64'(in_ready), 64'd1);
        tick();

        // Overflow
`ifdef SUM_ACC_SAT_EN
        exp_q.push_back('{sum: MAXV, cnt: 3'd4, ovf: 1'b1});
`else
        exp_q.push_back('{sum: MINV, cnt: 3'd4, ovf: 1'b1});
`endif
        send(MAXV, 1'b0); send(64'd1, 1'b0); send(64'd0, 1'b0); send(64'd0, 1'b0);
        drain();

        // Random frames with random out_ready
        rnd_rdy = 1'b1;
        for (int f = 0; f < 20; f++) begin
            len        = $urandom_range(1, 4);
            lone_flush = (len < 4) && ($urandom_range(0, 1) == 1);
            macc = '0;
            movf = 1'b0;
            for (int k = 0; k < len; k++) begin
                s[k] = {$urandom, $urandom};
                model_add(macc, movf, s[k], macc, movf);
            end
            e.sum = macc;
            e.cnt = CNT_W'(len);
            e.ovf = movf;
            exp_q.push_back(e);
            for (int k = 0; k < len; k++) begin
                send(s[k], (len < 4) && (k == len - 1) && !lone_flush);
            end
            if (lone_flush) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            drain();
        end
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
